// File: rtl/i2s_pkg.sv
// Shared defaults and channel encoding for the I2S capture and playback blocks.
package i2s_pkg;

    localparam int DEF_WIDTH                = 16;
    localparam int DEF_MAIN_TO_SERIAL       = 24;
    localparam int DEF_SERIAL_TO_LEFT_RIGHT = 64;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_t;

endpackage

// File: rtl/i2s_clock_gen.sv
// I2S master clocking: derives sclk and ws from mclk and tracks the slot within each ws half.
module i2s_clock_gen
    import i2s_pkg::*;
#(
    parameter int MAIN_TO_SERIAL       = DEF_MAIN_TO_SERIAL,
    parameter int SERIAL_TO_LEFT_RIGHT = DEF_SERIAL_TO_LEFT_RIGHT,
    localparam int SLOT_W              = $clog2(SERIAL_TO_LEFT_RIGHT / 2)
) (
    input  logic              mclk,
    input  logic              rst,
    output logic              sclk,
    output logic              ws,
    output logic              sclk_rise,
    output logic              sclk_fall,
    output logic [SLOT_W-1:0] slot_idx
);

    localparam int CNT_W = $clog2(MAIN_TO_SERIAL / 2);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAIN_TO_SERIAL / 2 - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SERIAL_TO_LEFT_RIGHT / 2 - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_sclk;
    logic              r_ws;
    logic [SLOT_W-1:0] r_slot;
    logic              w_toggle;

    // The strobes name the coming mclk edge, so users act on the same edge sclk changes.
    assign w_toggle  = (r_cnt == CNT_LAST);
    assign sclk_rise = w_toggle & ~r_sclk;
    assign sclk_fall = w_toggle & r_sclk;

    // sclk divider.
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_sclk <= 1'b0;
        end else if (w_toggle) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // Slot counter; the rise that toggles ws becomes slot 0 of the new half.
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_slot <= {SLOT_W{1'b0}};
            r_ws   <= 1'b0;
        end else if (sclk_rise) begin
            if (r_slot == SLOT_LAST) begin
                r_slot <= {SLOT_W{1'b0}};
                r_ws   <= ~r_ws;
            end else begin
                r_slot <= r_slot + SLOT_W'(1);
            end
        end
    end

    assign sclk     = r_sclk;
    assign ws       = r_ws;
    assign slot_idx = r_slot;

endmodule

// File: rtl/i2s_receiver.sv
// I2S master-mode receiver: deserialises sd_rx into left/right pairs behind a one-deep
// valid/ready output register with a sticky overrun flag.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int WIDTH                = DEF_WIDTH,
    parameter int MAIN_TO_SERIAL       = DEF_MAIN_TO_SERIAL,
    parameter int SERIAL_TO_LEFT_RIGHT = DEF_SERIAL_TO_LEFT_RIGHT
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             sd_rx,
    output logic             sclk,
    output logic             ws,
    output logic [WIDTH-1:0] rx_data_l,
    output logic [WIDTH-1:0] rx_data_r,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overrun
);

    localparam int SLOT_W = $clog2(SERIAL_TO_LEFT_RIGHT / 2);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SERIAL_TO_LEFT_RIGHT / 2 - 1);
    localparam logic [SLOT_W-1:0] SLOT_MSB  = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LSB  = SLOT_W'(WIDTH);

    logic              w_sclk;
    logic              w_ws;
    logic              w_sclk_rise;
    logic              w_sclk_fall_unused;
    logic [SLOT_W-1:0] w_slot_idx;
    logic [SLOT_W-1:0] w_ev_slot;
    i2s_ch_t           w_ev_ch;
    logic              w_arm_now;
    logic              w_capture;
    logic              w_complete;

    logic              r_armed;
    logic              r_done;
    logic [WIDTH-1:0]  r_shift_l;
    logic [WIDTH-1:0]  r_shift_r;
    logic [WIDTH-1:0]  r_data_l;
    logic [WIDTH-1:0]  r_data_r;
    logic              r_valid;
    logic              r_overrun;

    i2s_clock_gen #(
        .MAIN_TO_SERIAL       (MAIN_TO_SERIAL),
        .SERIAL_TO_LEFT_RIGHT (SERIAL_TO_LEFT_RIGHT)
    ) u_clock_gen (
        .mclk      (mclk),
        .rst       (rst),
        .sclk      (w_sclk),
        .ws        (w_ws),
        .sclk_rise (w_sclk_rise),
        .sclk_fall (w_sclk_fall_unused),
        .slot_idx  (w_slot_idx)
    );

    // Slot and channel of the rise event at the coming edge (clock_gen updates on that edge).
    always_comb begin
        w_ev_slot = {SLOT_W{1'b0}};
        w_ev_ch   = CH_LEFT;
        if (w_slot_idx == SLOT_LAST) begin
            w_ev_slot = {SLOT_W{1'b0}};
            w_ev_ch   = i2s_ch_t'(~w_ws);
        end else begin
            w_ev_slot = w_slot_idx + SLOT_W'(1);
            w_ev_ch   = i2s_ch_t'(w_ws);
        end
        w_arm_now  = w_sclk_rise & (w_slot_idx == SLOT_LAST) & w_ws;
        w_capture  = w_sclk_rise & r_armed & (w_ev_slot >= SLOT_MSB) & (w_ev_slot <= SLOT_LSB);
        w_complete = w_capture & (w_ev_ch == CH_RIGHT) & (w_ev_slot == SLOT_LSB);
    end

    // Arming and deserialisation; r_done marks the edge holding a full pair.
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_armed   <= 1'b0;
            r_done    <= 1'b0;
            r_shift_l <= {WIDTH{1'b0}};
            r_shift_r <= {WIDTH{1'b0}};
        end else begin
            r_done <= w_complete;
            if (w_arm_now) begin
                r_armed <= 1'b1;
            end
            if (w_capture) begin
                case (w_ev_ch)
                    CH_LEFT:  r_shift_l <= {r_shift_l[WIDTH-2:0], sd_rx};
                    CH_RIGHT: r_shift_r <= {r_shift_r[WIDTH-2:0], sd_rx};
                    default:  r_shift_l <= r_shift_l;
                endcase
            end
        end
    end

    // One-deep output register; a pair arriving while the old one is stuck is dropped.
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_data_l  <= {WIDTH{1'b0}};
            r_data_r  <= {WIDTH{1'b0}};
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_done) begin
            if (!r_valid || rx_ready) begin
                r_data_l <= r_shift_l;
                r_data_r <= r_shift_r;
                r_valid  <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign sclk      = w_sclk;
    assign ws        = w_ws;
    assign rx_data_l = r_data_l;
    assign rx_data_r = r_data_r;
    assign rx_valid  = r_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: an ADC model driven from frame timing, and a
// scoreboard of expected pairs feeding a model of the output register.
module tb_i2s_receiver;

    logic        mclk     = 1'b0;
    logic        rst      = 1'b1;
    logic        sd_rx    = 1'b0;
    logic        rx_ready = 1'b0;
    logic        sclk;
    logic        ws;
    logic [15:0] rx_data_l;
    logic [15:0] rx_data_r;
    logic        rx_valid;
    logic        overrun;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          rel      = 0;
    logic        ready_at_edge = 1'b0;
    logic        rst_at_edge   = 1'b1;
    bit          sb_on         = 1'b0;

    logic [15:0] tab_l [8];
    logic [15:0] tab_r [8];
    logic        pad_bit = 1'b0;

    logic [31:0] exp_q [$];
    logic        m_valid = 1'b0;
    logic        m_ovr   = 1'b0;
    logic [15:0] m_l     = 16'h0000;
    logic [15:0] m_r     = 16'h0000;
    logic [31:0] m_pair;
    int          bfm_n, bfm_slot, bfm_ch, bfm_f;

    always #5 mclk = ~mclk;

    i2s_receiver #(
        .WIDTH                (16),
        .MAIN_TO_SERIAL       (24),
        .SERIAL_TO_LEFT_RIGHT (64)
    ) dut (
        .mclk      (mclk),
        .rst       (rst),
        .sd_rx     (sd_rx),
        .sclk      (sclk),
        .ws        (ws),
        .rx_data_l (rx_data_l),
        .rx_data_r (rx_data_r),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .overrun   (overrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d after release)", tag, got, exp, rel);
        end
    endtask

    // Edge counter relative to reset release, plus snapshots of inputs seen at each edge.
    always @(posedge mclk) begin
        rel           <= rst ? 0 : rel + 1;
        ready_at_edge <= rx_ready;
        rst_at_edge   <= rst;
    end

    // ADC model, scoreboard and output-register model.
    always @(negedge mclk) begin
        if (rel % 24 == 0) begin
            bfm_n    = rel / 24 + 1;
            bfm_slot = bfm_n % 32;
            bfm_ch   = (bfm_n / 32) % 2;
            bfm_f    = (bfm_n >= 64) ? ((bfm_n - 64) / 64) % 8 : 0;
            if (bfm_n >= 64 && bfm_slot >= 1 && bfm_slot <= 16) begin
                sd_rx = (bfm_ch == 1) ? tab_r[bfm_f][16 - bfm_slot] : tab_l[bfm_f][16 - bfm_slot];
            end else begin
                sd_rx = pad_bit;
            end
            if (!rst_at_edge && bfm_n >= 64 && bfm_ch == 1 && bfm_slot == 16) begin
                exp_q.push_back({tab_l[bfm_f], tab_r[bfm_f]});
            end
        end

        if (rst_at_edge) begin
            exp_q.delete();
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_l     = 16'h0000;
            m_r     = 16'h0000;
        end else if (rel >= 2677 && (rel - 2677) % 1536 == 0) begin
            check_eq("sb_depth", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                m_pair = exp_q.pop_front();
                if (!m_valid || ready_at_edge) begin
                    m_l     = m_pair[31:16];
                    m_r     = m_pair[15:0];
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end else if (m_valid && ready_at_edge) begin
            m_valid = 1'b0;
        end

        if (sb_on) begin
            check_eq("rx_valid", 32'(rx_valid), 32'(m_valid));
            check_eq("overrun", 32'(overrun), 32'(m_ovr));
            check_eq("rx_data_l", 32'(rx_data_l), 32'(m_l));
            check_eq("rx_data_r", 32'(rx_data_r), 32'(m_r));
        end
    end

    task automatic set_frames(input logic [15:0] l0, input logic [15:0] r0,
                              input logic [15:0] l1, input logic [15:0] r1);
        tab_l[0] = l0;
        tab_r[0] = r0;
        for (int i = 1; i < 8; i++) begin
            tab_l[i] = l1;
            tab_r[i] = r1;
        end
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge mclk);
        rst = 1'b1;
        repeat (cycles) @(negedge mclk);
        check_eq("rst_sclk", 32'(sclk), 32'd0);
        check_eq("rst_ws", 32'(ws), 32'd0);
        check_eq("rst_data_l", 32'(rx_data_l), 32'd0);
        check_eq("rst_data_r", 32'(rx_data_r), 32'd0);
        check_eq("rst_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        sb_on = 1'b1;
        rst   = 1'b0;
    endtask

    task automatic wait_sig(input int which, input logic val, input int budget, output int at);
        logic s;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge mclk);
            case (which)
                0:       s = sclk;
                1:       s = ws;
                default: s = rx_valid;
            endcase
            if (s === val) begin
                at = rel;
                break;
            end
        end
    endtask

    task automatic wait_rel(input int target);
        for (int i = 0; i < target + 100; i++) begin
            if (rel >= target) break;
            @(negedge mclk);
        end
        check_eq("wait_rel", 32'(rel), 32'(target));
    endtask

    initial begin
        int at;

        // Reset, clock timing and basic capture
        set_frames(16'hA5C3, 16'h5A3C, 16'hA5C3, 16'h5A3C);
        pad_bit  = 1'b0;
        rx_ready = 1'b1;
        apply_reset(5);
        wait_sig(0, 1'b1, 100, at);   check_eq("sclk_rise1", 32'(at), 32'd12);
        wait_sig(0, 1'b0, 100, at);   check_eq("sclk_fall1", 32'(at), 32'd24);
        wait_sig(0, 1'b1, 100, at);   check_eq("sclk_rise2", 32'(at), 32'd36);
        wait_sig(1, 1'b1, 1000, at);  check_eq("ws_rise1", 32'(at), 32'd756);
        wait_sig(1, 1'b0, 1000, at);  check_eq("ws_fall1", 32'(at), 32'd1524);
        wait_sig(1, 1'b1, 1000, at);  check_eq("ws_rise2", 32'(at), 32'd2292);
        wait_sig(2, 1'b1, 1000, at);  check_eq("first_valid", 32'(at), 32'd2677);
        check_eq("basic_l", 32'(rx_data_l), 32'h0000A5C3);
        check_eq("basic_r", 32'(rx_data_r), 32'h00005A3C);
        wait_sig(2, 1'b0, 10, at);    check_eq("valid_pulse_end", 32'(at), 32'd2678);
        wait_sig(2, 1'b1, 2000, at);  check_eq("second_valid", 32'(at), 32'd4213);

        // Backpressure across two completions
        set_frames(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        rx_ready = 1'b0;
        apply_reset(5);
        wait_rel(4215);
        check_eq("bp_l", 32'(rx_data_l), 32'h00001111);
        check_eq("bp_r", 32'(rx_data_r), 32'h00002222);
        check_eq("bp_valid", 32'(rx_valid), 32'd1);
        check_eq("bp_overrun", 32'(overrun), 32'd1);
        rx_ready = 1'b1;
        @(negedge mclk);
        rx_ready = 1'b0;
        check_eq("bp_release", 32'(rx_valid), 32'd0);
        check_eq("bp_sticky", 32'(overrun), 32'd1);

        // Handshake coinciding with a completion
        set_frames(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        rx_ready = 1'b0;
        apply_reset(5);
        wait_rel(4212);
        check_eq("sim_pre_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        @(negedge mclk);
        rx_ready = 1'b0;
        check_eq("sim_valid", 32'(rx_valid), 32'd1);
        check_eq("sim_l", 32'(rx_data_l), 32'h00009ABC);
        check_eq("sim_r", 32'(rx_data_r), 32'h0000DEF0);
        check_eq("sim_overrun", 32'(overrun), 32'd0);

        // Slot masking: ones outside the data slots must not leak in
        set_frames(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        pad_bit  = 1'b1;
        rx_ready = 1'b1;
        apply_reset(5);
        wait_sig(2, 1'b1, 3000, at);  check_eq("mask_valid", 32'(at), 32'd2677);
        check_eq("mask_l", 32'(rx_data_l), 32'd0);
        check_eq("mask_r", 32'(rx_data_r), 32'd0);
        pad_bit = 1'b0;

        // Reset during right-channel slot 8
        set_frames(16'hCAFE, 16'hBEEF, 16'hCAFE, 16'hBEEF);
        rx_ready = 1'b1;
        apply_reset(5);
        wait_rel(2490);
        check_eq("mf_ws_right", 32'(ws), 32'd1);
        check_eq("mf_no_valid", 32'(rx_valid), 32'd0);
        apply_reset(3);
        wait_sig(2, 1'b1, 3000, at);  check_eq("mf_first_valid", 32'(at), 32'd2677);
        check_eq("mf_l", 32'(rx_data_l), 32'h0000CAFE);
        check_eq("mf_r", 32'(rx_data_r), 32'h0000BEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
